// File: rtl/uart_decimal_line_receiver_pkg.sv
// Shared constants and types for the decimal-over-UART line receiver.
// The ASCII codes match the ones the line-formatting transmit side emits.
package uart_decimal_line_receiver_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0d;
  localparam logic [7:0] ASCII_LF    = 8'h0a;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  // Serial receiver states, in frame order.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // True for the ASCII decimal digits '0'..'9'.
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/uart_decimal_line_receiver_uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser on rx followed by a mid-bit
// sampling FSM. Emits a one-cycle strobe per framed byte or framing error.
module uart_rx_byte
  import uart_decimal_line_receiver_pkg::*;
#(
  parameter int CLOCK_DIVISOR = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       framing_error
);

  localparam int CNT_W = $clog2(CLOCK_DIVISOR);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLOCK_DIVISOR / 2);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLOCK_DIVISOR - 1);

  logic             rx_meta_r;
  logic             rx_sync_r;
  rx_state_t        state_r;
  rx_state_t        state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_next_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_next_s;
  logic             byte_fire_s;
  logic             frame_err_s;
  logic [7:0]       byte_out_r;
  logic             byte_valid_r;
  logic             framing_error_r;

  // State register, datapath registers, synchroniser and registered strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_r       <= 1'b1;
      rx_sync_r       <= 1'b1;
      state_r         <= RX_IDLE;
      cnt_r           <= '0;
      bit_idx_r       <= 3'd0;
      shift_r         <= 8'h00;
      byte_out_r      <= 8'h00;
      byte_valid_r    <= 1'b0;
      framing_error_r <= 1'b0;
    end else begin
      rx_meta_r       <= rx;
      rx_sync_r       <= rx_meta_r;
      state_r         <= state_next_s;
      cnt_r           <= cnt_next_s;
      bit_idx_r       <= bit_idx_next_s;
      shift_r         <= shift_next_s;
      byte_valid_r    <= byte_fire_s;
      framing_error_r <= frame_err_s;
      if (byte_fire_s) begin
        byte_out_r <= shift_r;
      end
    end
  end

  // Next-state logic: walk start, eight data bits and stop at mid-bit ticks.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RX_IDLE: begin
        if (!rx_sync_r) state_next_s = RX_START;
        else            state_next_s = RX_IDLE;
      end
      RX_START: begin
        if (cnt_r == HALF_BIT) begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (!rx_sync_r) state_next_s = RX_DATA;
          else            state_next_s = RX_IDLE;
        end else begin
          state_next_s = RX_START;
        end
      end
      RX_DATA: begin
        if ((cnt_r == LAST_TICK) && (bit_idx_r == 3'd7)) state_next_s = RX_STOP;
        else                                              state_next_s = RX_DATA;
      end
      RX_STOP: begin
        if (cnt_r == LAST_TICK) state_next_s = RX_IDLE;
        else                    state_next_s = RX_STOP;
      end
      default: state_next_s = RX_IDLE;
    endcase
  end

  // Output/datapath logic: bit timer, shift register and stop-bit verdict.
  always_comb begin
    cnt_next_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    byte_fire_s    = 1'b0;
    frame_err_s    = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_next_s     = '0;
        bit_idx_next_s = 3'd0;
      end
      RX_START: begin
        // Restart the timer at mid start bit so data ticks land mid-bit.
        if (cnt_r == HALF_BIT) cnt_next_s = '0;
        else                   cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      RX_DATA: begin
        if (cnt_r == LAST_TICK) begin
          cnt_next_s     = '0;
          shift_next_s   = {rx_sync_r, shift_r[7:1]};
          bit_idx_next_s = bit_idx_r + 3'd1;
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RX_STOP: begin
        if (cnt_r == LAST_TICK) begin
          cnt_next_s = '0;
          if (rx_sync_r) byte_fire_s = 1'b1;
          else           frame_err_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        cnt_next_s     = '0;
        bit_idx_next_s = 3'd0;
      end
    endcase
  end

  assign byte_out      = byte_out_r;
  assign byte_valid    = byte_valid_r;
  assign framing_error = framing_error_r;

endmodule

// File: rtl/uart_decimal_line_receiver.sv
// Decimal line receiver: parses ASCII decimal lines arriving over UART into
// a binary value, with strobes for accepted values and malformed lines.
module uart_decimal_line_receiver
  import uart_decimal_line_receiver_pkg::*;
#(
  parameter int CLOCK_DIVISOR = 104,
  parameter int VALUE_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  output logic [VALUE_WIDTH-1:0] value,
  output logic                   value_valid,
  output logic                   framing_error,
  output logic                   parse_error,
  output logic                   overflow_error
);

  // Four headroom bits hold acc*10+9 for any acc up to the saturation limit.
  localparam int ACC_W = VALUE_WIDTH + 4;
  localparam logic [ACC_W-1:0] ACC_MAX = {{4{1'b0}}, {VALUE_WIDTH{1'b1}}};

  logic [7:0]             rx_byte_s;
  logic                   rx_valid_s;
  logic [ACC_W-1:0]       acc_r;
  logic [ACC_W-1:0]       acc_next_s;
  logic [ACC_W-1:0]       product_s;
  logic [7:0]             digit_count_r;
  logic [7:0]             digit_count_next_s;
  logic                   bad_r;
  logic                   bad_next_s;
  logic                   ovf_r;
  logic                   ovf_next_s;
  logic [VALUE_WIDTH-1:0] value_r;
  logic [VALUE_WIDTH-1:0] value_next_s;
  logic                   value_valid_s;
  logic                   parse_error_s;
  logic                   overflow_error_s;
  logic                   value_valid_r;
  logic                   parse_error_r;
  logic                   overflow_error_r;

  uart_rx_byte #(
    .CLOCK_DIVISOR(CLOCK_DIVISOR)
  ) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .byte_out     (rx_byte_s),
    .byte_valid   (rx_valid_s),
    .framing_error(framing_error)
  );

  assign byte_out   = rx_byte_s;
  assign byte_valid = rx_valid_s;

  // Multiply-by-ten as shift-and-add, then add the incoming digit.
  assign product_s = (acc_r << 3'd3) + (acc_r << 3'd1) + {{VALUE_WIDTH{1'b0}}, rx_byte_s[3:0]};

  // Parser: one byte per strobe; terminators resolve the line and clear it.
  always_comb begin
    acc_next_s         = acc_r;
    digit_count_next_s = digit_count_r;
    bad_next_s         = bad_r;
    ovf_next_s         = ovf_r;
    value_next_s       = value_r;
    value_valid_s      = 1'b0;
    parse_error_s      = 1'b0;
    overflow_error_s   = 1'b0;
    if (rx_valid_s) begin
      if (is_digit(rx_byte_s)) begin
        // The count only needs to distinguish zero from non-zero, so it saturates.
        if (digit_count_r == 8'hFF) digit_count_next_s = digit_count_r;
        else                        digit_count_next_s = digit_count_r + 8'd1;
        if (product_s > ACC_MAX) begin
          acc_next_s = ACC_MAX;
          ovf_next_s = 1'b1;
        end else begin
          acc_next_s = product_s;
        end
      end else if (rx_byte_s == ASCII_SPACE) begin
        // Spaces are padding and leave the line state alone.
        acc_next_s = acc_r;
      end else if ((rx_byte_s == ASCII_CR) || (rx_byte_s == ASCII_LF)) begin
        if (bad_r) begin
          parse_error_s = 1'b1;
        end else if (ovf_r) begin
          overflow_error_s = 1'b1;
        end else if (digit_count_r != 8'd0) begin
          value_next_s  = acc_r[VALUE_WIDTH-1:0];
          value_valid_s = 1'b1;
        end else begin
          // Empty line, typically the LF half of CRLF.
          value_valid_s = 1'b0;
        end
        acc_next_s         = '0;
        digit_count_next_s = 8'd0;
        bad_next_s         = 1'b0;
        ovf_next_s         = 1'b0;
      end else begin
        bad_next_s = 1'b1;
      end
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Parser state and registered result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r            <= '0;
      digit_count_r    <= 8'd0;
      bad_r            <= 1'b0;
      ovf_r            <= 1'b0;
      value_r          <= '0;
      value_valid_r    <= 1'b0;
      parse_error_r    <= 1'b0;
      overflow_error_r <= 1'b0;
    end else begin
      acc_r            <= acc_next_s;
      digit_count_r    <= digit_count_next_s;
      bad_r            <= bad_next_s;
      ovf_r            <= ovf_next_s;
      value_r          <= value_next_s;
      value_valid_r    <= value_valid_s;
      parse_error_r    <= parse_error_s;
      overflow_error_r <= overflow_error_s;
    end
  end

  assign value          = value_r;
  assign value_valid    = value_valid_r;
  assign parse_error    = parse_error_r;
  assign overflow_error = overflow_error_r;

endmodule

// File: tb/tb_uart_decimal_line_receiver.sv
// Directed bench for uart_decimal_line_receiver: serial stimulus at 104
// clocks/bit with a scoreboard of expected bytes and line results.
module tb_uart_decimal_line_receiver;

  localparam int DIV = 104;

  localparam logic [2:0] K_VALUE = 3'b001;
  localparam logic [2:0] K_PARSE = 3'b010;
  localparam logic [2:0] K_OVF   = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] val;
  } result_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [15:0] value;
  logic        value_valid;
  logic        framing_error;
  logic        parse_error;
  logic        overflow_error;

  int total = 0;
  int bad   = 0;
  int bytes_seen  = 0;
  int frames_seen = 0;
  int frame_pending = 0;

  logic [7:0] exp_bytes[$];
  result_t    exp_res[$];

  uart_decimal_line_receiver #(
    .CLOCK_DIVISOR(DIV),
    .VALUE_WIDTH  (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .value         (value),
    .value_valid   (value_valid),
    .framing_error (framing_error),
    .parse_error   (parse_error),
    .overflow_error(overflow_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) exp_bytes.push_back(b);
    else          frame_pending++;
    rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(DIV);
    end
    rx = stop_bit;
    idle(DIV);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
    end
  endtask

  task automatic push_res(input logic [2:0] k, input logic [15:0] v);
    result_t r;
    r.kind = k;
    r.val  = v;
    exp_res.push_back(r);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT strobes.
  always @(negedge clock) begin
    if (byte_valid) begin
      bytes_seen++;
      check("byte_expected", 32'(exp_bytes.size() > 0), 32'd1);
      if (exp_bytes.size() > 0) begin
        check("byte_out", 32'(byte_out), 32'(exp_bytes.pop_front()));
      end
    end
    if (value_valid || parse_error || overflow_error) begin
      check("result_expected", 32'(exp_res.size() > 0), 32'd1);
      if (exp_res.size() > 0) begin
        result_t r;
        r = exp_res.pop_front();
        check("result_kind", 32'({overflow_error, parse_error, value_valid}), 32'(r.kind));
        check("result_value", 32'(value), 32'(r.val));
      end
    end
    if (framing_error) begin
      frames_seen++;
      check("framing_expected", 32'(frame_pending > 0), 32'd1);
      if (frame_pending > 0) frame_pending--;
    end
  end

  initial begin
    int b_before;
    int f_before;
    logic [7:0] nine;

    // Reset state
    idle(5);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_value_valid", 32'(value_valid), 32'd0);
    check("rst_framing", 32'(framing_error), 32'd0);
    check("rst_parse", 32'(parse_error), 32'd0);
    check("rst_overflow", 32'(overflow_error), 32'd0);
    reset = 1'b0;
    idle(10);

    // "1234\r\n": one value, six bytes, empty LF line silent
    b_before = bytes_seen;
    push_res(K_VALUE, 16'h04D2);
    send_str("1234");
    send_byte(8'h0d, 1'b1);
    send_byte(8'h0a, 1'b1);
    idle(20);
    check("crlf_byte_count", 32'(bytes_seen - b_before), 32'd6);
    check("crlf_value", 32'(value), 32'h04D2);

    // Upper boundary and first overflowing value
    push_res(K_VALUE, 16'hFFFF);
    send_str("65535");
    send_byte(8'h0d, 1'b1);
    push_res(K_OVF, 16'hFFFF);
    send_str("65536");
    send_byte(8'h0d, 1'b1);
    idle(20);
    check("ovf_value_held", 32'(value), 32'hFFFF);

    // Non-digit line, then recovery
    push_res(K_PARSE, 16'hFFFF);
    send_str("12a4");
    send_byte(8'h0a, 1'b1);
    push_res(K_VALUE, 16'h0007);
    send_str("7");
    send_byte(8'h0a, 1'b1);
    idle(20);
    check("recover_value", 32'(value), 32'h0007);

    // Framing error leaves line empty; lone CR produces nothing
    f_before = frames_seen;
    send_byte(8'h35, 1'b0);
    idle(200);
    send_byte(8'h0d, 1'b1);
    idle(20);
    check("framing_count", 32'(frames_seen - f_before), 32'd1);
    check("framing_value_held", 32'(value), 32'h0007);

    // Short low pulse is rejected as a glitch
    b_before = bytes_seen;
    f_before = frames_seen;
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(300);
    check("glitch_bytes", 32'(bytes_seen - b_before), 32'd0);
    check("glitch_frames", 32'(frames_seen - f_before), 32'd0);

    // Reset during data bit 4 of '9' abandons the byte
    nine = 8'h39;
    rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = nine[i];
      idle(DIV);
    end
    rx = nine[4];
    idle(DIV / 2);
    reset = 1'b1;
    rx = 1'b1;
    idle(3);
    check("midreset_value", 32'(value), 32'd0);
    check("midreset_byte_out", 32'(byte_out), 32'd0);
    reset = 1'b0;
    idle(DIV * 6);
    push_res(K_VALUE, 16'h0008);
    send_str("8");
    send_byte(8'h0d, 1'b1);
    idle(50);
    check("after_reset_value", 32'(value), 32'h0008);

    // Everything expected must have been observed
    check("bytes_drained", 32'(exp_bytes.size()), 32'd0);
    check("results_drained", 32'(exp_res.size()), 32'd0);
    check("frames_drained", 32'(frame_pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
